ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//  Downstream consumer of the processor top's 13-bit SSD debug value; drives the board's 4-digit 7-segment display.
//  Converts the binary value to 4 BCD digits with a sequential shift-add-3 (double-dabble) converter.
//  Time-multiplexes the digits onto shared active-low segment and anode lines.
//  Sits at the board top, between the processor top's SSD output and the FPGA pins.
// PARAMETERS
//  N_IN         13   binary input width; max 8191, so 4 digits always suffice
//  REFRESH_BITS 17   scan counter width; digit select = cnt[REFRESH_BITS-1 -: 2]
// PORTS
//  clk        in   1   single system clock; all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  num        in   13  binary value to display
//  anode      out  4   active-low digit enables; anode[3] = thousands (leftmost), anode[0] = ones
//  seg        out  7   active-low segments; seg[6:0] = {a,b,c,d,e,f,g}
//  bcd        out  16  last completed conversion {thou,hund,tens,ones}, for debug and verification
//  conv_done  out  1   1-cycle pulse when bcd updates
// BEHAVIOUR
//  Reset (rst=0, async): anode=4'b1111, seg=7'h7F, bcd=0, conv_done=0, scan cnt=0, FSM=IDLE.
//  Converter FSM, one iteration per clk:
//   - IDLE: capture num into shift reg, clear scratch BCD, it=0, go to SHIFT.
//   - SHIFT: per cycle, add 3 to each scratch nibble >=5, then shift {bcd,bin} left 1, it++.
//     After N_IN iterations, go to DONE.
//   - DONE: bcd<=scratch, conv_done=1 for this cycle, go to IDLE.
//  Latency: num sampled in IDLE, bcd valid N_IN+2 = 15 cycles later; conversions run back-to-back.
//  num is sampled only in IDLE; changes during SHIFT or DONE take effect on the next conversion.
//  Display always shows the registered bcd, never scratch; no tearing mid-conversion.
//  Scan: cnt free-runs and wraps 2^REFRESH_BITS-1 -> 0.
//   Digit select d = cnt top 2 bits; anode = ~(4'b1 << d); seg = LUT(bcd nibble d).
//  anode and seg are registered together and change in the same cycle; no ghosting from skew.
//  LUT active-low, e.g. 0 -> 7'b0000001, 1 -> 7'b1001111, 8 -> 7'b0000000.
//   Nibbles >9 cannot occur; the default arm outputs blank (7'h7F).
//  Reset mid-conversion discards the conversion. The display blanks until the first DONE after
//   reset (bcd=0 displays "0000" once the scan runs).
// CONFIGURATION
//  SSD_BLANK_LEADING_ZERO_EN defined: leading-zero digits above the highest non-zero digit are
//   shown blank (seg=7'h7F, anode still cycles). The ones digit is never blanked, so value 0 shows "   0".
//  Undefined: all 4 digits always shown, zero-padded ("0042").
// STRUCTURE
//  Package ssd_pkg: NUM_DIGITS=4, SEG_BLANK=7'h7F, seg_lut function (digit->active-low
//   segments), FSM state enum {IDLE,SHIFT,DONE}.
//  Sub-module bin2bcd_seq: FSM and shift-add-3 datapath; ports clk,rst,num,bcd,conv_done.
//  Top holds the scan counter, digit mux, LUT and output registers.
// TESTING (bench overrides REFRESH_BITS=4 for fast scan)
//  1. Hold rst=0 -> anode=4'b1111, seg=7'h7F, bcd=0, conv_done=0, independent of clk.
//  2. num=1234 after reset -> conv_done pulses, bcd=16'h1234 within 15 clk.
//     Scan shows anode 1110/1101/1011/0111 with seg for 4/3/2/1.
//  3. num=8191 -> bcd=16'h8191. num=0 -> bcd=16'h0000.
//     With SSD_BLANK_LEADING_ZERO_EN: only anode[0] shows 7'b0000001, other digits blank.
//  4. num=42 -> "0042" without the macro; blank,blank,4,2 with it.
//  5. num 1234 -> 999 at 5 cycles into SHIFT -> next bcd=16'h1234, the following bcd=16'h0999.
//  6. Assert rst mid-SHIFT for 1 cycle -> outputs return to reset values at once.
//     First post-reset conv_done carries the current num.

Source files
------------

// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the 7-segment scan driver:
//   NUM_DIGITS   - number of display digits (4 BCD nibbles)
//   SEG_BLANK    - active-low pattern with every segment off
//   conv_state_t - binary-to-BCD converter FSM states
//   seg_lut      - BCD digit -> active-low segments {a,b,c,d,e,f,g}
//   add3_ge5     - double-dabble nibble correction (add 3 when >= 5)
// ----------------------------------------------------------------------------
package ssd_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-low segment pattern for one decimal digit; anything above 9 blanks.
    function automatic logic [6:0] seg_lut(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // A nibble >= 5 would exceed 9 after the next doubling, so pre-correct it.
    function automatic logic [3:0] add3_ge5(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 (double-dabble) binary to BCD converter. One
// conversion takes N_IN+2 cycles (IDLE capture, N_IN SHIFT steps, DONE) and
// conversions run back-to-back. num is sampled only in IDLE.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   num       in   binary value, N_IN bits
//   bcd       out  last completed conversion {thou,hund,tens,ones}
//   conv_done out  one-cycle pulse coincident with a bcd update
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int N_IN = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         num,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    conv_done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IT_W  = $clog2(N_IN);

    conv_state_t      state_r;
    conv_state_t      state_nxt_s;
    logic [N_IN-1:0]  bin_r;
    logic [BCD_W-1:0] scr_r;
    logic [BCD_W-1:0] adj_s;
    logic [IT_W-1:0]  it_r;
    logic [BCD_W-1:0] bcd_r;
    logic             conv_done_r;
    logic             last_s;

    assign bcd       = bcd_r;
    assign conv_done = conv_done_r;

    // Converter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave SHIFT once the final bit has been shifted in.
    always_comb begin
        state_nxt_s = state_r;
        last_s      = (it_r == IT_W'(N_IN - 1));
        case (state_r)
            IDLE:  state_nxt_s = SHIFT;
            SHIFT: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-nibble add-3 correction applied to the scratch BCD before each shift.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj_s[4*i +: 4] = add3_ge5(scr_r[4*i +: 4]);
        end
    end

    // Datapath: capture, shift {scratch,bin} left, publish the result in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_r       <= '0;
            scr_r       <= '0;
            it_r        <= '0;
            bcd_r       <= '0;
            conv_done_r <= 1'b0;
        end else begin
            conv_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    bin_r <= num;
                    scr_r <= '0;
                    it_r  <= '0;
                end
                SHIFT: begin
                    // Top nibble never reaches >=8 before the last shift for
                    // inputs up to 8191, so dropping adj_s MSB loses nothing.
                    scr_r <= {adj_s[BCD_W-2:0], bin_r[N_IN-1]};
                    bin_r <= {bin_r[N_IN-2:0], 1'b0};
                    it_r  <= it_r + IT_W'(1);
                end
                DONE: begin
                    bcd_r       <= scr_r;
                    conv_done_r <= 1'b1;
                end
                default: begin
                    conv_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ----------------------------------------------------------------------------
// ssd_scan_driver
// Shows a 13-bit binary value on a 4-digit multiplexed 7-segment display.
// The value is converted to BCD by bin2bcd_seq; a free-running scan counter
// selects one digit at a time, and anode/seg are registered together so they
// always change on the same edge. The display stays blank until the first
// conversion after reset completes.
// Build option: define SSD_BLANK_LEADING_ZERO_EN to blank leading zero digits
// (the ones digit is always shown); otherwise all four digits are zero-padded.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   num       in   binary value to display (N_IN bits)
//   anode     out  active-low digit enables, anode[3] = thousands
//   seg       out  active-low segments {a,b,c,d,e,f,g}
//   bcd       out  last completed conversion {thou,hund,tens,ones}
//   conv_done out  one-cycle pulse when bcd updates
// ----------------------------------------------------------------------------
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int N_IN         = 13,
    parameter int REFRESH_BITS = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         num,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    conv_done
);

    logic [REFRESH_BITS-1:0]   cnt_r;
    logic                      valid_r;
    logic [NUM_DIGITS-1:0]     anode_r;
    logic [6:0]                seg_r;
    logic [4*NUM_DIGITS-1:0]   bcd_s;
    logic                      conv_done_s;
    logic                      show_s;
    logic [1:0]                dsel_s;
    logic [3:0]                digit_s;
    logic [NUM_DIGITS-1:0]     blank_s;
    logic [NUM_DIGITS-1:0]     anode_nxt_s;
    logic [6:0]                seg_nxt_s;

    bin2bcd_seq #(
        .N_IN (N_IN)
    ) u_bin2bcd (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .bcd       (bcd_s),
        .conv_done (conv_done_s)
    );

    assign bcd       = bcd_s;
    assign conv_done = conv_done_s;
    assign anode     = anode_r;
    assign seg       = seg_r;

    // Leading-zero mask: a digit blanks only if it and every digit above it are zero.
    always_comb begin
        blank_s = 4'b0000;
`ifdef SSD_BLANK_LEADING_ZERO_EN
        blank_s[3] = (bcd_s[15:12] == 4'd0);
        blank_s[2] = blank_s[3] && (bcd_s[11:8] == 4'd0);
        blank_s[1] = blank_s[2] && (bcd_s[7:4] == 4'd0);
        blank_s[0] = 1'b0;
`else
        blank_s = 4'b0000;
`endif
    end

    // Digit mux and segment decode for the digit the scan counter points at.
    always_comb begin
        anode_nxt_s = 4'b1111;
        seg_nxt_s   = SEG_BLANK;
        // conv_done is folded in so the first result shows without an extra cycle.
        show_s      = valid_r || conv_done_s;
        dsel_s      = cnt_r[REFRESH_BITS-1 -: 2];
        digit_s     = bcd_s[{dsel_s, 2'b00} +: 4];
        if (show_s) begin
            anode_nxt_s = ~(4'b0001 << dsel_s);
            if (blank_s[dsel_s]) begin
                seg_nxt_s = SEG_BLANK;
            end else begin
                seg_nxt_s = seg_lut(digit_s);
            end
        end else begin
            anode_nxt_s = 4'b1111;
            seg_nxt_s   = SEG_BLANK;
        end
    end

    // Scan counter, display-valid flag and the registered anode/seg outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= '0;
            valid_r <= 1'b0;
            anode_r <= 4'b1111;
            seg_r   <= SEG_BLANK;
        end else begin
            cnt_r   <= cnt_r + REFRESH_BITS'(1);
            valid_r <= show_s;
            anode_r <= anode_nxt_s;
            seg_r   <= seg_nxt_s;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_ssd_scan_driver
// Self-checking bench: a cycle-count based model predicts bcd, conv_done,
// anode and seg every cycle; directed phases pin the model with literal
// BCD values and segment patterns, followed by randomized input changes.
// ----------------------------------------------------------------------------
module tb_ssd_scan_driver;

    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] num = 13'd0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [15:0] bcd;
    logic        conv_done;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    ssd_scan_driver #(
        .N_IN         (13),
        .REFRESH_BITS (RB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .anode     (anode),
        .seg       (seg),
        .bcd       (bcd),
        .conv_done (conv_done)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] b, input int d);
        logic [15:0] hi;
        hi = b >> (4 * d);
`ifdef SSD_BLANK_LEADING_ZERO_EN
        if (d > 0 && hi == 16'd0) return 7'h7F;
`endif
        return lut[hi[3:0]];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: edge count since reset release drives everything. A conversion
    // samples num at edges 1,16,31,... and publishes at edges 15,30,45,...
    // The display shows from edge 16 on, digit = (edges-1)/4 mod 4, using the
    // bcd present before the edge.
    int          m_edge  = 0;
    int          m_cap   = 0;
    logic [15:0] m_bcd   = 16'd0;
    logic        m_done  = 1'b0;
    logic [3:0]  m_anode = 4'hF;
    logic [6:0]  m_seg   = 7'h7F;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edge  <= 0;
            m_cap   <= 0;
            m_bcd   <= 16'd0;
            m_done  <= 1'b0;
            m_anode <= 4'hF;
            m_seg   <= 7'h7F;
        end else begin
            m_edge <= m_edge + 1;
            if (m_edge + 1 >= 16) begin
                m_anode <= ~(4'b0001 << ((m_edge / (1 << (RB - 2))) % 4));
                m_seg   <= model_seg(m_bcd, (m_edge / (1 << (RB - 2))) % 4);
            end else begin
                m_anode <= 4'hF;
                m_seg   <= 7'h7F;
            end
            if (m_edge % 15 == 0) m_cap <= int'(num);
            m_done <= ((m_edge + 1) % 15 == 0);
            if ((m_edge + 1) % 15 == 0) m_bcd <= to_bcd(m_cap);
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("bcd", int'(bcd), int'(m_bcd));
            chk("conv_done", int'(conv_done), int'(m_done));
            chk("anode", int'(anode), int'(m_anode));
            chk("seg", int'(seg), int'(m_seg));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!conv_done && n < 40);
        chk("conv_done_seen", int'(conv_done), 1);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_anode"}, int'(anode), 4'hF);
        chk({nm, "_seg"}, int'(seg), 7'h7F);
        chk({nm, "_bcd"}, int'(bcd), 0);
        chk({nm, "_done"}, int'(conv_done), 0);
    endtask

    // Scan every digit slot and compare seg against literal patterns e[d].
    task automatic scan_check(input string nm, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] e [4];
        logic [3:0] seen;
        int d;
        e[3] = e3; e[2] = e2; e[1] = e1; e[0] = e0;
        seen = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (anode)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (d < 0) begin
                chk({nm, "_anode_onehot"}, int'(anode), 4'b1110);
            end else begin
                seen[d] = 1'b1;
                chk({nm, "_seg"}, int'(seg), int'(e[d]));
            end
        end
        chk({nm, "_all_digits"}, int'(seen), 4'hF);
    endtask

    task automatic convert(input string nm, input int v, input logic [15:0] exp);
        int n;
        wait_done(n);
        num = 13'(v);
        wait_done(n);
        chk(nm, int'(bcd), int'(exp));
    endtask

    initial begin
        int n;
        num = 13'd1234;
        #1 rst = 1'b0;
        #1 check_reset_vals("reset_noclk");
        repeat (3) @(negedge clk);
        check_reset_vals("reset_clk");
        checking = 1'b1;
        #2 rst = 1'b1;

        // First conversion after reset: latency and literal result.
        wait_done(n);
        chk("latency", n, 15);
        chk("bcd_1234", int'(bcd), 16'h1234);
        scan_check("scan_1234", 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);

        convert("bcd_8191", 8191, 16'h8191);
        scan_check("scan_8191", 7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111);

        convert("bcd_0", 0, 16'h0000);
`ifdef SSD_BLANK_LEADING_ZERO_EN
        scan_check("scan_0", 7'h7F, 7'h7F, 7'h7F, 7'b0000001);
`else
        scan_check("scan_0", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
`endif

        convert("bcd_42", 42, 16'h0042);
`ifdef SSD_BLANK_LEADING_ZERO_EN
        scan_check("scan_42", 7'h7F, 7'h7F, 7'b1001100, 7'b0010010);
`else
        scan_check("scan_42", 7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010);
`endif

        // num changes 5 cycles into SHIFT: current conversion keeps the old value.
        wait_done(n);
        num = 13'd1234;
        repeat (6) @(negedge clk);
        num = 13'd999;
        wait_done(n);
        chk("midshift_old", int'(bcd), 16'h1234);
        wait_done(n);
        chk("midshift_new", int'(bcd), 16'h0999);

        // Reset mid-SHIFT: outputs drop at once, conversion discarded.
        wait_done(n);
        repeat (5) @(negedge clk);
        num = 13'd4321;
        #2 rst = 1'b0;
        #1 check_reset_vals("reset_mid");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        wait_done(n);
        chk("latency_post_reset", n, 15);
        chk("bcd_post_reset", int'(bcd), 16'h4321);

        // Randomized values changed at random points; the compare process checks all.
        for (int i = 0; i < 40; i++) begin
            num = 13'($urandom_range(0, 8191));
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
